instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Program-side driver for the 16-bit processor core.
- Holds a small host-loadable program memory and walks a program counter through it.
- Issues each instruction word on the core's instruction input and holds it for the number of cycles that opcode needs to complete.
- Captures the core's output bus on OUT instructions and reports completion to the host.

Parameters:
- ADDR_WIDTH, 5, program memory address width; depth = 2**ADDR_WIDTH words of 16 bits.
- MOVE_STEPS, 1, execute cycles for opcodes 000 (mv), 001 (mvi), 100 (out).
- ALU_STEPS, 3, execute cycles for opcodes 010 (add) and 011 (sub).

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins execution at address 0.
- prog_we  in  1  program memory write enable.
- prog_addr  in  ADDR_WIDTH  program write address.
- prog_data  in  16  program write data.
- proc_out  in  16  processor output bus, sampled on OUT instructions.
- iin  out  16  instruction word driven to the processor.
- result  out  16  last value captured by an OUT instruction.
- result_valid  out  1  one-cycle pulse when result updates.
- busy  out  1  high in FETCH and EXEC.
- done  out  1  high in DONE.
- pc  out  ADDR_WIDTH  current program counter.

Behaviour:
- Reset (async, resetn=0) clears iin, result, result_valid, busy, done and pc to 0, and sets state to IDLE. Program memory is not cleared.
- Memory write: when prog_we=1 in IDLE or DONE, mem[prog_addr] <= prog_data on the clock edge. prog_we in FETCH/EXEC is ignored.
- start is honoured only in IDLE or DONE. It sets pc=0, clears done and goes to FETCH. If start and prog_we arrive in the same cycle, the write occurs and start is ignored. start while busy is ignored.
- FETCH (1 cycle): instr_reg <= mem[pc]. Next state is EXEC.
- EXEC, entry cycle:
  - if instr_reg[15:13]==3'b111 (halt), go to DONE without driving iin or advancing pc;
  - otherwise iin <= instr_reg and step counter <= N-1, where N=ALU_STEPS for 010/011 and MOVE_STEPS for all other opcodes (101/110 are treated as moves).
- EXEC hold: iin stays constant while the counter decrements. When the counter reaches 0:
  - if opcode==100, result <= proc_out and result_valid pulses for 1 cycle;
  - if pc==2**ADDR_WIDTH-1, go to DONE and pc holds;
  - otherwise pc <= pc+1 and go to FETCH.
- Latency: each instruction costs 1+N cycles. iin first changes in the cycle after FETCH.
- DONE: done=1 and busy=0; iin holds the last issued word. Remains in DONE until start or reset.
- IDLE: busy=0, done=0.
- Reset asserted mid-EXEC aborts immediately: no result capture and no pc advance.

Optional Feature:
- INSTR_SEQ_SINGLE_STEP_EN defined adds two input ports:
  - step_mode (1 bit);
  - step (1-bit pulse).
- With step_mode=1, the sequencer waits in FETCH after the fetch completes until a step pulse arrives, then enters EXEC. A step pulse that arrives during the wait is consumed; pulses outside that wait are ignored.
- With step_mode=0, or with the macro undefined, the ports do not exist and execution runs freely.

Test Plan:
- Reset, then load mem[0]=16'h2000 (mvi) and mem[1]=16'hE000 (halt), then pulse start: iin=16'h2000 for exactly 1 cycle window, pc goes 0->1, done=1 five cycles after start, result stays 0.
- Load mem[0]=16'h4000 (add), mem[1]=16'hE000, then start: iin=16'h4000 is held for 3 consecutive cycles, then FETCH of address 1.
- Load mem[0]=16'h8000 (out), mem[1]=halt, with proc_out=16'hBEEF, then start: result=16'hBEEF with a single-cycle result_valid pulse 2 cycles after start.
- Fill all 32 words with 16'h0000, then start: pc reaches 31 and done=1 with pc=31, with no wrap to 0; done takes 64 cycles.
- Run the program from the add test, pulse resetn low during the 2nd EXEC cycle: all outputs are 0 and state is IDLE. Then start without reloading: the program re-executes from the retained memory.
- With INSTR_SEQ_SINGLE_STEP_EN defined and step_mode=1: iin stays unchanged until a step pulse arrives. A start pulse or prog_we during busy has no effect.

Source files
------------

// File: rtl/instr_sequencer.sv
// Program-side driver for the 16-bit core: walks a host-loaded program memory and issues each word
// for its opcode's step count. Define INSTR_SEQ_SINGLE_STEP_EN to add step_mode/step gating of FETCH.
module instr_sequencer #(
    parameter int ADDR_WIDTH = 5,
    parameter int MOVE_STEPS = 1,
    parameter int ALU_STEPS  = 3
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [15:0]           prog_data,
    input  logic [15:0]           proc_out,
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    input  logic                  step_mode,
    input  logic                  step,
`endif
    output logic [15:0]           iin,
    output logic [15:0]           result,
    output logic                  result_valid,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] pc
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int MAX_STEPS = (ALU_STEPS > MOVE_STEPS) ? ALU_STEPS : MOVE_STEPS;
    localparam int CNT_W     = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
    localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_STEPS - 1);
    localparam logic [CNT_W-1:0] ALU_LAST  = CNT_W'(ALU_STEPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [15:0]           r_mem [DEPTH];
    logic [15:0]           r_instr;
    logic [15:0]           r_iin;
    logic [15:0]           r_result;
    logic                  r_result_valid;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_first;

    logic                  w_halt;
    logic                  w_alu;
    logic                  w_out;
    logic                  w_halt_now;
    logic                  w_issue;
    logic [CNT_W-1:0]      w_cnt_cur;
    logic                  w_cnt_zero;
    logic                  w_pc_last;
    logic                  w_quiet;
    logic                  w_prog_wr;
    logic                  w_start;
    logic                  w_fetch_rd;
    logic                  w_fetch_go;

    assign w_halt     = (r_instr[15:13] == 3'b111);
    assign w_alu      = (r_instr[15:14] == 2'b01);
    assign w_out      = (r_instr[15:13] == 3'b100);
    assign w_halt_now = (r_state == S_EXEC) && r_first && w_halt;
    assign w_issue    = (r_state == S_EXEC) && r_first && !w_halt;
    // On the entry cycle the counter register is stale, so the step count comes straight from the opcode.
    assign w_cnt_cur  = r_first ? (w_alu ? ALU_LAST : MOVE_LAST) : r_cnt;
    assign w_cnt_zero = (w_cnt_cur == '0);
    assign w_pc_last  = (r_pc == {ADDR_WIDTH{1'b1}});
    assign w_quiet    = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_prog_wr  = w_quiet && prog_we;
    assign w_start    = w_quiet && start && !prog_we;

`ifdef INSTR_SEQ_SINGLE_STEP_EN
    logic r_fetched;

    assign w_fetch_rd = (r_state == S_FETCH) && !r_fetched;
    assign w_fetch_go = r_fetched ? (step || !step_mode) : !step_mode;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_fetched <= 1'b0;
        end else begin
            r_fetched <= (r_state == S_FETCH) && !w_fetch_go;
        end
    end
`else
    assign w_fetch_rd = (r_state == S_FETCH);
    assign w_fetch_go = 1'b1;
`endif

    // Program memory kept reset-free so it maps onto block RAM and survives resetn.
    always_ff @(posedge clock) begin
        if (w_prog_wr) begin
            r_mem[prog_addr] <= prog_data;
        end
        if (w_fetch_rd) begin
            r_instr <= r_mem[r_pc];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_start) w_state_next = S_FETCH;
            S_FETCH:        if (w_fetch_go) w_state_next = S_EXEC;
            S_EXEC: begin
                if (w_halt_now) begin
                    w_state_next = S_DONE;
                end else if (w_cnt_zero) begin
                    w_state_next = w_pc_last ? S_DONE : S_FETCH;
                end
            end
            default:        w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_FETCH) || (r_state == S_EXEC);
        done = (r_state == S_DONE);
        iin  = w_issue ? r_instr : r_iin;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pc           <= '0;
            r_iin          <= '0;
            r_cnt          <= '0;
            r_first        <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_first        <= (r_state == S_FETCH);
            if (w_start) begin
                r_pc <= '0;
            end
            if (w_issue) begin
                r_iin <= r_instr;
            end
            if ((r_state == S_EXEC) && !w_halt_now) begin
                if (!w_cnt_zero) begin
                    r_cnt <= w_cnt_cur - 1'b1;
                end else begin
                    if (w_out) begin
                        r_result       <= proc_out;
                        r_result_valid <= 1'b1;
                    end
                    if (!w_pc_last) begin
                        r_pc <= r_pc + 1'b1;
                    end
                end
            end
        end
    end

    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign pc           = r_pc;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer; OUT results go through an expected-value queue.
// Single-step steps run only when INSTR_SEQ_SINGLE_STEP_EN is defined.
module tb_instr_sequencer;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [15:0]   prog_data = '0;
    logic [15:0]   proc_out = '0;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    logic          step_mode = 1'b0;
    logic          step = 1'b0;
`endif
    logic [15:0]   iin;
    logic [15:0]   result;
    logic          result_valid;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    instr_sequencer #(.ADDR_WIDTH(AW), .MOVE_STEPS(1), .ALU_STEPS(3)) dut (
        .clock(clock),
        .resetn(resetn),
        .start(start),
        .prog_we(prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .proc_out(proc_out),
`ifdef INSTR_SEQ_SINGLE_STEP_EN
        .step_mode(step_mode),
        .step(step),
`endif
        .iin(iin),
        .result(result),
        .result_valid(result_valid),
        .busy(busy),
        .done(done),
        .pc(pc)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: land on the falling edge, then score any result the DUT reported.
    task automatic cyc();
        logic [15:0] e;
        @(negedge clock);
        if (result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("result_valid_spurious", 32'(result_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", 32'(result), 32'(e));
                $display("txn out: result=%h expected=%h", result, e);
            end
        end
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [15:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        cyc();
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic run_add(input string pfx);
        pulse_start();
        chk({pfx, "_pc0"}, 32'(pc), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk({pfx, "_iin_hold"}, 32'(iin), 32'h4000);
            chk({pfx, "_pc_hold"}, 32'(pc), 32'd0);
        end
        cyc();
        chk({pfx, "_fetch_pc1"}, 32'(pc), 32'd1);
        chk({pfx, "_busy"}, 32'(busy), 32'd1);
        cyc();
        chk({pfx, "_done_early"}, 32'(done), 32'd0);
        cyc();
        chk({pfx, "_done"}, 32'(done), 32'd1);
        $display("txn %s: add program complete pc=%0d iin=%h", pfx, pc, iin);
    endtask

    initial begin
        int n;
        logic [AW-1:0] prev_pc;
        logic wrapped;

        // Reset state
        cyc(); cyc();
        chk("rst_iin", 32'(iin), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_rv", 32'(result_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        resetn = 1'b1;
        cyc();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        // mvi then halt
        load(0, 16'h2000);
        load(1, 16'hE000);
        pulse_start();
        chk("mvi_fetch_iin", 32'(iin), 32'd0);
        chk("mvi_fetch_busy", 32'(busy), 32'd1);
        cyc();
        chk("mvi_exec_iin", 32'(iin), 32'h2000);
        chk("mvi_exec_pc", 32'(pc), 32'd0);
        cyc();
        chk("mvi_pc_adv", 32'(pc), 32'd1);
        cyc();
        chk("mvi_halt_done", 32'(done), 32'd0);
        cyc();
        chk("mvi_done", 32'(done), 32'd1);
        chk("mvi_busy", 32'(busy), 32'd0);
        chk("mvi_result", 32'(result), 32'd0);
        chk("mvi_iin_hold", 32'(iin), 32'h2000);
        $display("txn mvi: done pc=%0d iin=%h", pc, iin);

        // add holds for three cycles
        load(0, 16'h4000);
        run_add("add");

        // out captures proc_out
        load(0, 16'h8000);
        proc_out = 16'hBEEF;
        exp_q.push_back(16'hBEEF);
        pulse_start();
        cyc();
        chk("out_rv_early", 32'(result_valid), 32'd0);
        cyc();
        chk("out_rv_pulse", 32'(result_valid), 32'd1);
        chk("out_result", 32'(result), 32'hBEEF);
        cyc();
        chk("out_rv_single", 32'(result_valid), 32'd0);
        cyc();
        chk("out_done", 32'(done), 32'd1);
        chk("out_sb_empty", 32'(exp_q.size()), 32'd0);

        // start coinciding with a write is dropped
        start = 1'b1; prog_we = 1'b1; prog_addr = 5'd2; prog_data = 16'h0000;
        cyc();
        start = 1'b0; prog_we = 1'b0;
        chk("we_start_busy", 32'(busy), 32'd0);
        chk("we_start_done", 32'(done), 32'd1);

        // all-zero program runs to the last address without wrapping
        for (int a = 0; a < 32; a++) load(AW'(a), 16'h0000);
        proc_out = 16'h5555;
        pulse_start();
        n = 1; prev_pc = pc; wrapped = 1'b0;
        while (done !== 1'b1 && n < 200) begin
            if (n == 10) start = 1'b1;
            if (n == 11) start = 1'b0;
            if (n == 20) begin prog_we = 1'b1; prog_addr = 5'd25; prog_data = 16'h8000; end
            if (n == 21) prog_we = 1'b0;
            cyc();
            n++;
            if (pc < prev_pc) wrapped = 1'b1;
            prev_pc = pc;
        end
        chk("fill_cycles", 32'(n), 32'd65);
        chk("fill_pc", 32'(pc), 32'd31);
        chk("fill_nowrap", 32'(wrapped), 32'd0);
        chk("fill_result_kept", 32'(result), 32'hBEEF);
        cyc(); cyc();
        chk("fill_pc_hold", 32'(pc), 32'd31);
        chk("fill_done_hold", 32'(done), 32'd1);
        $display("txn fill: done after %0d cycles pc=%0d", n, pc);

        // reset during the second add execute cycle
        load(0, 16'h4000);
        load(1, 16'hE000);
        pulse_start();
        cyc(); cyc();
        chk("abort_pre_iin", 32'(iin), 32'h4000);
        #1 resetn = 1'b0;
        #1;
        chk("abort_iin", 32'(iin), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_rv", 32'(result_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_pc", 32'(pc), 32'd0);
        cyc();
        resetn = 1'b1;
        cyc(); cyc();
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_idle_done", 32'(done), 32'd0);
        run_add("rerun");

`ifdef INSTR_SEQ_SINGLE_STEP_EN
        load(0, 16'h2000);
        load(1, 16'h8000);
        load(2, 16'hE000);
        proc_out = 16'h1234;
        exp_q.push_back(16'h1234);
        step_mode = 1'b1;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) start = 1'b1;
            if (i == 2) begin start = 1'b0; prog_we = 1'b1; prog_addr = 5'd1; prog_data = 16'hE000; end
            cyc();
            prog_we = 1'b0;
            chk("ss_wait_iin", 32'(iin), 32'h4000);
            chk("ss_wait_pc", 32'(pc), 32'd0);
            chk("ss_wait_busy", 32'(busy), 32'd1);
        end
        step = 1'b1;
        cyc();
        step = 1'b0;
        chk("ss_mvi_iin", 32'(iin), 32'h2000);
        cyc();
        chk("ss_pc1", 32'(pc), 32'd1);
        cyc(); cyc();
        chk("ss_wait2_iin", 32'(iin), 32'h2000);
        step = 1'b1;
        cyc();
        step = 1'b0;
        chk("ss_out_iin", 32'(iin), 32'h8000);
        cyc();
        chk("ss_pc2", 32'(pc), 32'd2);
        cyc();
        step = 1'b1;
        cyc();
        step = 1'b0;
        chk("ss_halt_busy", 32'(busy), 32'd1);
        cyc();
        chk("ss_done", 32'(done), 32'd1);
        step_mode = 1'b0;
        $display("txn step: program complete pc=%0d result=%h", pc, result);
`endif

        cyc();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
